// File: rtl/upsample_replay_fifo_pkg.sv
// Shared parameters for the upsample replay FIFO: RAM implementation selector, default geometry, mode encodings.
// No logic; imported by the top level and the RAM wrapper.
package upsample_replay_fifo_pkg;

    typedef enum logic [0:0] {
        DEV_BEHAV  = 1'b0,
        DEV_VENDOR = 1'b1
    } device_e;

    // Selects how upsample_sdp_ram is realised for the target technology.
    localparam device_e device = DEV_BEHAV;

    localparam int DEF_DATA_W     = 256;
    localparam int DEF_RATIO_LOG2 = 1;
    localparam int DEF_DEPTH_W    = 10;

    localparam logic MODE_REPLAY  = 1'b0;
    localparam logic MODE_CONSUME = 1'b1;

endpackage

// File: rtl/upsample_sdp_ram.sv
// Simple dual-port asymmetric RAM: full-word writes, slice-wide registered reads (1-cycle latency).
// No backpressure; rd_data_o holds its value when rd_en_i is low.
module upsample_sdp_ram
    import upsample_replay_fifo_pkg::*;
#(
    parameter int      DATA_W     = DEF_DATA_W,
    parameter int      RATIO_LOG2 = DEF_RATIO_LOG2,
    parameter int      DEPTH_W    = DEF_DEPTH_W,
    parameter device_e DEV        = device,
    localparam int     DATA_R     = DATA_W >> RATIO_LOG2,
    localparam int     DEPTH_R    = DEPTH_W + RATIO_LOG2
) (
    input  logic               system_clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [DEPTH_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0]  wr_data_i,
    input  logic               rd_en_i,
    input  logic [DEPTH_R-1:0] rd_addr_i,
    output logic [DATA_R-1:0]  rd_data_o
);

    localparam int RATIO = 2 ** RATIO_LOG2;

    logic [DATA_R-1:0] rd_slice;
    logic [DATA_R-1:0] rd_data_q;
    logic [DATA_R-1:0] rd_data_d;

    generate
        if (DEV == DEV_VENDOR) begin : g_vendor
            // Wide-word array with output slice select, matching the vendor primitive's native organisation.
            logic [DATA_W-1:0]     mem_w [2**DEPTH_W];
            logic [DATA_W-1:0]     rd_word;
            logic [RATIO_LOG2-1:0] rd_sel;

            always_ff @(posedge system_clk) begin
                if (wr_en_i) begin
                    mem_w[wr_addr_i] <= wr_data_i;
                end
            end

            assign rd_word  = mem_w[rd_addr_i[DEPTH_R-1:RATIO_LOG2]];
            assign rd_sel   = rd_addr_i[RATIO_LOG2-1:0];
            assign rd_slice = rd_word[rd_sel*DATA_R +: DATA_R];
        end else begin : g_behav
            logic [DATA_R-1:0] mem_n [2**DEPTH_R];

            always_ff @(posedge system_clk) begin
                if (wr_en_i) begin
                    for (int k = 0; k < RATIO; k++) begin
                        mem_n[{wr_addr_i, RATIO_LOG2'(k)}] <= wr_data_i[k*DATA_R +: DATA_R];
                    end
                end
            end

            assign rd_slice = mem_n[rd_addr_i];
        end
    endgenerate

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = rd_slice;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/upsample_replay_fifo.sv
// Width-converting FIFO (DATA_W in, DATA_R slices out) with commit and replay read pointers; 1-cycle read latency.
// Writes dropped while o_full; reads dropped while o_empty or i_rewind.
module upsample_replay_fifo
    import upsample_replay_fifo_pkg::*;
#(
    parameter int  DATA_W                = DEF_DATA_W,
    parameter int  RATIO_LOG2            = DEF_RATIO_LOG2,
    parameter int  DEPTH_W               = DEF_DEPTH_W,
    parameter int  ALMOST_FULL_THRESHOLD = 1000,
    localparam int DATA_R                = DATA_W >> RATIO_LOG2,
    localparam int DEPTH_R               = DEPTH_W + RATIO_LOG2
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    input  logic              i_mode,
    input  logic              i_rewind,
    input  logic [DEPTH_R:0]  i_almost_empty_threshold,
    output logic [DATA_R-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_full,
    output logic              o_almost_full,
    output logic              o_empty,
    output logic              o_almost_empty,
    output logic              o_ready_for_output,
    output logic [DEPTH_R:0]  o_count
);

    localparam int                 CW       = DEPTH_R + 1;
    localparam logic [CW-1:0]      RATIO_C  = CW'(2 ** RATIO_LOG2);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW:0]        ROUND_UP = (CW + 1)'(2 ** RATIO_LOG2 - 1);
    localparam logic [DEPTH_W+1:0] CAP_W    = (DEPTH_W + 2)'(2 ** DEPTH_W);
    localparam logic [DEPTH_W-1:0] WPTR_ONE = DEPTH_W'(1);
    localparam logic [DEPTH_R-1:0] RPTR_ONE = DEPTH_R'(1);

    logic [DEPTH_W-1:0] wptr_q, wptr_d;
    logic [DEPTH_R-1:0] rptr_q, rptr_d;
    logic [DEPTH_R-1:0] vptr_q, vptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      vavail_q, vavail_d;
    logic               rdvalid_q, rdvalid_d;

    logic [CW:0]        used_sum;
    logic [DEPTH_W+1:0] used_w;
    logic [CW-1:0]      avail;
    logic               full;
    logic               empty;
    logic               almost_empty;
    logic               wr_acc;
    logic               rd_acc;
    logic               cons_rd;
    logic               rep_rd;
    logic [DEPTH_R-1:0] rd_addr;

    // A partly read word still occupies its slot, so round the slice count up to words.
    assign used_sum = {1'b0, count_q} + ROUND_UP;
    assign used_w   = used_sum[CW:RATIO_LOG2];
    assign full     = (used_w == CAP_W);

    assign avail        = (i_mode == MODE_CONSUME) ? count_q : vavail_q;
    assign empty        = (avail == '0);
    assign almost_empty = (avail < i_almost_empty_threshold);

    assign wr_acc  = i_wren & ~full;
    assign rd_acc  = i_rden & ~empty & ~i_rewind;
    assign cons_rd = rd_acc & (i_mode == MODE_CONSUME);
    assign rep_rd  = rd_acc & (i_mode == MODE_REPLAY);
    assign rd_addr = (i_mode == MODE_CONSUME) ? rptr_q : vptr_q;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        vptr_d    = vptr_q;
        count_d   = count_q;
        vavail_d  = vavail_q;
        rdvalid_d = rd_acc;

        if (wr_acc) begin
            count_d = count_d + RATIO_C;
            wptr_d  = wptr_q + WPTR_ONE;
        end
        if (cons_rd) begin
            count_d = count_d - CNT_ONE;
            rptr_d  = rptr_q + RPTR_ONE;
        end

        // Replay state shadows the commit state outside replay, so entering replay starts at the oldest slice.
        if (i_mode == MODE_CONSUME) begin
            vptr_d   = rptr_d;
            vavail_d = count_d;
        end else if (i_rewind) begin
            vptr_d   = rptr_q;
            vavail_d = count_d;
        end else begin
            if (wr_acc) begin
                vavail_d = vavail_d + RATIO_C;
            end
            if (rep_rd) begin
                vavail_d = vavail_d - CNT_ONE;
                vptr_d   = vptr_q + RPTR_ONE;
            end
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            vptr_q    <= '0;
            count_q   <= '0;
            vavail_q  <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            vptr_q    <= vptr_d;
            count_q   <= count_d;
            vavail_q  <= vavail_d;
            rdvalid_q <= rdvalid_d;
        end
    end

    upsample_sdp_ram #(
        .DATA_W     (DATA_W),
        .RATIO_LOG2 (RATIO_LOG2),
        .DEPTH_W    (DEPTH_W),
        .DEV        (device)
    ) u_ram (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .wr_en_i    (wr_acc),
        .wr_addr_i  (wptr_q),
        .wr_data_i  (i_wrdata),
        .rd_en_i    (rd_acc),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (o_rddata)
    );

    assign o_rdvalid          = rdvalid_q;
    assign o_full             = full;
    assign o_almost_full      = (32'(used_w) >= ALMOST_FULL_THRESHOLD);
    assign o_empty            = empty;
    assign o_almost_empty     = almost_empty;
    assign o_ready_for_output = (i_mode == MODE_CONSUME) ? ~empty : ~almost_empty;
    assign o_count            = count_q;

endmodule

// File: tb/tb_upsample_replay_fifo.sv
// Bench for upsample_replay_fifo: default-geometry instance A plus a 128-bit, 4:1, 16-word instance B for wrap tests.
// Read data is checked by per-instance scoreboard monitors; flags and counts are checked inline.
module tb_upsample_replay_fifo;

    localparam int AW = 256, AR = 128, ADR = 11;
    localparam int BW = 128, BR = 32,  BDR = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          a_wren, a_rden, a_mode, a_rewind;
    logic [AW-1:0] a_wrdata;
    logic [ADR:0]  a_thr;
    logic [AR-1:0] a_rddata;
    logic          a_rdvalid, a_full, a_afull, a_empty, a_aempty, a_rfo;
    logic [ADR:0]  a_count;

    logic          b_wren, b_rden, b_mode, b_rewind;
    logic [BW-1:0] b_wrdata;
    logic [BDR:0]  b_thr;
    logic [BR-1:0] b_rddata;
    logic          b_rdvalid, b_full, b_afull, b_empty, b_aempty, b_rfo;
    logic [BDR:0]  b_count;

    upsample_replay_fifo dut_a (
        .system_clk (clk), .rst_n (rst_n),
        .i_wren (a_wren), .i_wrdata (a_wrdata), .i_rden (a_rden), .i_mode (a_mode),
        .i_rewind (a_rewind), .i_almost_empty_threshold (a_thr),
        .o_rddata (a_rddata), .o_rdvalid (a_rdvalid), .o_full (a_full), .o_almost_full (a_afull),
        .o_empty (a_empty), .o_almost_empty (a_aempty), .o_ready_for_output (a_rfo), .o_count (a_count)
    );

    upsample_replay_fifo #(
        .DATA_W (BW), .RATIO_LOG2 (2), .DEPTH_W (4), .ALMOST_FULL_THRESHOLD (14)
    ) dut_b (
        .system_clk (clk), .rst_n (rst_n),
        .i_wren (b_wren), .i_wrdata (b_wrdata), .i_rden (b_rden), .i_mode (b_mode),
        .i_rewind (b_rewind), .i_almost_empty_threshold (b_thr),
        .o_rddata (b_rddata), .o_rdvalid (b_rdvalid), .o_full (b_full), .o_almost_full (b_afull),
        .o_empty (b_empty), .o_almost_empty (b_aempty), .o_ready_for_output (b_rfo), .o_count (b_count)
    );

    int errors = 0;
    int checks = 0;
    logic [AR-1:0] qa[$];
    logic [BR-1:0] qb[$];
    logic [AR-1:0] ea;
    logic [BR-1:0] eb;

    // Word k of A: 32-bit lane l = {k, l, A5}; slice s is lanes 4s..4s+3.
    function automatic logic [AW-1:0] mk_a(int k);
        logic [AW-1:0] w;
        for (int l = 0; l < 8; l++) w[l*32 +: 32] = {16'(k), 8'(l), 8'hA5};
        return w;
    endfunction

    function automatic logic [AR-1:0] sl_a(int k, int s);
        logic [AR-1:0] e;
        for (int l = 0; l < 4; l++) e[l*32 +: 32] = {16'(k), 8'(4*s + l), 8'hA5};
        return e;
    endfunction

    function automatic logic [BW-1:0] mk_b(int k);
        logic [BW-1:0] w;
        for (int l = 0; l < 4; l++) w[l*32 +: 32] = {16'(k), 8'(l), 8'h3C};
        return w;
    endfunction

    function automatic logic [BR-1:0] sl_b(int k, int s);
        return {16'(k), 8'(s), 8'h3C};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(int k);
        a_wren = 1'b1; a_wrdata = mk_a(k);
        step();
        a_wren = 1'b0;
    endtask

    task automatic rd_a(int k, int s);
        a_rden = 1'b1; qa.push_back(sl_a(k, s));
        step();
        a_rden = 1'b0;
    endtask

    task automatic wr_b(int k);
        b_wren = 1'b1; b_wrdata = mk_b(k);
        step();
        b_wren = 1'b0;
    endtask

    task automatic rd_b(int k, int s);
        b_rden = 1'b1; qb.push_back(sl_b(k, s));
        step();
        b_rden = 1'b0;
    endtask

    task automatic chk_reset_a(string tag);
        chk({tag, "_rdvalid"}, 32'(a_rdvalid), 0);
        chk({tag, "_rddata_nz"}, 32'(a_rddata != '0), 0);
        chk({tag, "_count"}, 32'(a_count), 0);
        chk({tag, "_empty"}, 32'(a_empty), 1);
        chk({tag, "_aempty"}, 32'(a_aempty), 1);
        chk({tag, "_full"}, 32'(a_full), 0);
        chk({tag, "_afull"}, 32'(a_afull), 0);
        chk({tag, "_rfo"}, 32'(a_rfo), 0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        qa.delete(); qb.delete();
        step(); step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_rdvalid) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_data: unexpected slice %h", a_rddata);
            end else begin
                ea = qa.pop_front();
                if (a_rddata !== ea) begin
                    errors++;
                    $display("FAIL a_data: got %h expected %h", a_rddata, ea);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_rdvalid) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_data: unexpected slice %h", b_rddata);
            end else begin
                eb = qb.pop_front();
                if (b_rddata !== eb) begin
                    errors++;
                    $display("FAIL b_data: got %h expected %h", b_rddata, eb);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        a_wren = 0; a_rden = 0; a_mode = 1'b1; a_rewind = 0; a_wrdata = '0; a_thr = 12'd4;
        b_wren = 0; b_rden = 0; b_mode = 1'b1; b_rewind = 0; b_wrdata = '0; b_thr = 7'd4;
        #1;
        chk_reset_a("rst0");
        chk("rst0_b_empty", 32'(b_empty), 1);
        step(); step();
        rst_n = 1'b1;

        // First write into empty FIFO with a same-cycle read: read must be rejected.
        a_wren = 1'b1; a_wrdata = mk_a(100); a_rden = 1'b1;
        step();
        a_wren = 1'b0; a_rden = 1'b0;
        chk("first_wr_rd_rdvalid", 32'(a_rdvalid), 0);
        chk("first_wr_rd_count", 32'(a_count), 2);
        rd_a(100, 0); rd_a(100, 1);

        // Basic ordering, consume mode.
        for (int k = 0; k < 4; k++) wr_a(k);
        chk("t1_count8", 32'(a_count), 8);
        chk("t1_rfo", 32'(a_rfo), 1);
        for (int k = 0; k < 4; k++) for (int s = 0; s < 2; s++) rd_a(k, s);
        step();
        chk("t1_idle_rdvalid", 32'(a_rdvalid), 0);
        chk("t1_count0", 32'(a_count), 0);
        chk("t1_empty", 32'(a_empty), 1);

        // Fill to capacity.
        for (int i = 0; i < 1024; i++) begin
            wr_a(i);
            if (i == 998)  chk("fill_afull_999w", 32'(a_afull), 0);
            if (i == 999)  chk("fill_afull_1000w", 32'(a_afull), 1);
            if (i == 1022) chk("fill_full_1023w", 32'(a_full), 0);
        end
        chk("fill_full", 32'(a_full), 1);
        chk("fill_count", 32'(a_count), 2048);
        wr_a(5000);
        chk("drop_count", 32'(a_count), 2048);
        rd_a(0, 0);
        chk("one_rd_count", 32'(a_count), 2047);
        chk("one_rd_full", 32'(a_full), 1);
        rd_a(0, 1);
        chk("two_rd_count", 32'(a_count), 2046);
        chk("two_rd_full", 32'(a_full), 0);
        rd_a(1, 0);
        step();
        apply_reset();

        // Replay, rewind, then consume.
        for (int k = 10; k < 14; k++) wr_a(k);
        a_mode = 1'b0;
        #1;
        chk("rp_enter_empty", 32'(a_empty), 0);
        chk("rp_enter_rfo", 32'(a_rfo), 1);
        for (int k = 10; k < 14; k++) for (int s = 0; s < 2; s++) rd_a(k, s);
        chk("rp_count8", 32'(a_count), 8);
        chk("rp_empty", 32'(a_empty), 1);
        chk("rp_rfo", 32'(a_rfo), 0);
        wr_a(14);
        chk("rp_wr_empty", 32'(a_empty), 0);
        rd_a(14, 0); rd_a(14, 1);
        a_rewind = 1'b1; a_rden = 1'b1;
        step();
        a_rewind = 1'b0; a_rden = 1'b0;
        chk("rewind_rdvalid", 32'(a_rdvalid), 0);
        chk("rewind_empty", 32'(a_empty), 0);
        for (int k = 10; k < 15; k++) for (int s = 0; s < 2; s++) rd_a(k, s);
        chk("rp2_count", 32'(a_count), 10);
        a_mode = 1'b1;
        for (int k = 10; k < 15; k++) for (int s = 0; s < 2; s++) rd_a(k, s);
        step();
        chk("rp_consume_count", 32'(a_count), 0);
        chk("rp_consume_empty", 32'(a_empty), 1);

        // Simultaneous write and consume read.
        for (int k = 20; k < 23; k++) wr_a(k);
        rd_a(20, 0);
        chk("sim_count5", 32'(a_count), 5);
        a_wren = 1'b1; a_wrdata = mk_a(23); a_rden = 1'b1; qa.push_back(sl_a(20, 1));
        step();
        a_wren = 1'b0; a_rden = 1'b0;
        chk("sim_count6", 32'(a_count), 6);
        for (int k = 21; k < 24; k++) for (int s = 0; s < 2; s++) rd_a(k, s);
        step();
        chk("sim_drain_count", 32'(a_count), 0);

        // Pointer wrap on instance B, starting from an offset.
        for (int k = 900; k < 903; k++) wr_b(k);
        for (int k = 900; k < 903; k++) for (int s = 0; s < 4; s++) rd_b(k, s);
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < 16; j++) wr_b(c*16 + j);
            chk("b_full", 32'(b_full), 1);
            chk("b_afull", 32'(b_afull), 1);
            chk("b_count64", 32'(b_count), 64);
            for (int j = 0; j < 16; j++) for (int s = 0; s < 4; s++) rd_b(c*16 + j, s);
            step();
            chk("b_count0", 32'(b_count), 0);
            chk("b_empty", 32'(b_empty), 1);
        end

        // Reset mid-burst, then resume from address 0.
        wr_a(30); wr_a(31);
        a_wren = 1'b1; a_wrdata = mk_a(32); a_rden = 1'b1; qa.push_back(sl_a(30, 0));
        step();
        a_wren = 1'b0; a_rden = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_a("midrst");
        qa.delete();
        step();
        rst_n = 1'b1;
        wr_a(40);
        rd_a(40, 0); rd_a(40, 1);
        step();
        chk("post_rst_count", 32'(a_count), 0);

        for (int i = 0; i < 8 && (qa.size() + qb.size()) > 0; i++) step();
        chk("sb_pending", 32'(qa.size() + qb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/upsample_replay_fifo.md
# upsample_replay_fifo

Parametrised width-converting FIFO for the upsample datapath: accepts DATA_W-bit words and returns them as 2^RATIO_LOG2 narrower DATA_R-bit slices. It keeps a commit read pointer and a replay read pointer, so a row can be re-read any number of times before it is consumed. It sits between the feature-map writer and the upsample output stage and supersedes the fixed 256→128 upsample FIFO with exact full/empty tracking, arbitrary ratio and rewind.

## Interface
- DATA_W, 256, write word width; must be divisible by 2^RATIO_LOG2
- RATIO_LOG2, 1, log2 of slices per word; DATA_R = DATA_W >> RATIO_LOG2
- DEPTH_W, 10, log2 of word capacity; DEPTH_R = DEPTH_W + RATIO_LOG2
- ALMOST_FULL_THRESHOLD, 1000, word count at or above which o_almost_full asserts
- system_clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- i_wren  in  1  write request; ignored while o_full
- i_wrdata  in  DATA_W  write word
- i_rden  in  1  read request; ignored while o_empty or i_rewind
- i_mode  in  1  0 = replay (read does not free space), 1 = consume
- i_rewind  in  1  replay pointer := commit pointer (replay mode only)
- i_almost_empty_threshold  in  DEPTH_R+1  slice threshold for o_almost_empty
- o_rddata  out  DATA_R  read slice
- o_rdvalid  out  1  o_rddata valid this cycle
- o_full  out  1  no free word slot
- o_almost_full  out  1  used words >= ALMOST_FULL_THRESHOLD
- o_empty  out  1  no slice available in current mode
- o_almost_empty  out  1  available slices < threshold
- o_ready_for_output  out  1  i_mode ? !o_empty : !o_almost_empty
- o_count  out  DEPTH_R+1  committed occupancy in slices

## Operation
- Pointers: wptr (DEPTH_W bits, words), rptr and vptr (DEPTH_R bits, slices); all wrap modulo capacity.
- Slice order: slice k of a word = i_wrdata[k*DATA_R +: DATA_R]; slice 0 is read first. Read address = {word, slice}.
- count (DEPTH_R+1 bits): +2^RATIO_LOG2 on accepted write, −1 on accepted consume read; both in the same cycle gives a net change of +RATIO−1.
- used_w = (count + RATIO−1) >> RATIO_LOG2, so a partly read word still holds its slot. o_full = (used_w == 2^DEPTH_W).
- vavail: slices readable by vptr. It is reloaded with next count whenever i_mode=1 or i_rewind=1. In replay mode it changes by +RATIO per write and −1 per read.
- Consume mode: read uses rptr. vptr follows rptr's next value every cycle, so entering replay starts at the oldest unconsumed slice.
- Replay mode: read uses vptr and leaves rptr and count unchanged. i_rewind loads vptr := rptr and has priority over a read in the same cycle.
- o_empty = i_mode ? (count==0) : (vavail==0). avail = i_mode ? count : vavail. o_almost_empty = avail < threshold.
- No read/write address collision is possible: the write address is always a free slot and reads only touch occupied slices, so no exception path is needed.
- i_mode is sampled every cycle and takes effect for requests in that same cycle.

## Timing
- Read latency is 1 cycle: for an accepted read in cycle N, o_rddata and o_rdvalid are valid in cycle N+1. o_rddata holds its value otherwise.
- Writes are visible to reads in the cycle after acceptance. A read in the same cycle as the first write into an empty FIFO is rejected.
- Flags are combinational from registered state. They reflect accepted operations from the next cycle.
- Reset (asynchronous, any time, including mid-burst): pointers, count and vavail clear to 0; o_rddata=0; o_rdvalid=0; o_empty=1; o_almost_empty=1 unless threshold=0; o_full=0; o_almost_full=0; o_count=0; o_ready_for_output=0.
- Throughput: one write and one read per cycle are sustained.

## Structure
- Shared parameters include: the `device` selector, default DATA_W/RATIO_LOG2/DEPTH_W, and the mode encodings (MODE_REPLAY=0, MODE_CONSUME=1).
- Sub-module upsample_sdp_ram: simple dual-port, asymmetric (DATA_W write / DATA_R read), registered read. It is a vendor IP or a behavioural model selected by `device`.
- The top level holds only the pointer, counter and flag logic.

## Test plan
- Default parameters: write words W0..W3, then consume 8 reads → slices W0[127:0], W0[255:128], W1[127:0], … in order; o_count 8→0; o_empty=1 after the last read.
- Fill 1024 words → o_full=1 at count 2048; o_almost_full=1 from word 1000; a 1025th write is dropped; one consume read leaves o_full=1; two reads clear it.
- Replay mode with 4 words: read 8 slices, assert i_rewind, read 8 again → identical sequences; o_count stays 8; then consume 8 → same data, o_count reaches 0.
- Simultaneous write and consume read at count 5 → count 6. In replay mode, i_rewind together with i_rden → no o_rdvalid next cycle and vptr = rptr.
- Pointer wrap over 3 full fill/drain cycles with RATIO_LOG2=2, DATA_W=128 → data intact across the wrap.
- Assert rst_n low mid-burst → all outputs take reset values immediately; a subsequent write/read works from address 0.
